// File: rtl/ahb_to_picorv32_mem_bridge.sv
// AHB-Lite slave that issues one PicoRV32-style native memory request per AHB
// transfer, with big-endian byte strobes and a watchdog against silent targets.
module ahb_to_picorv32_mem_bridge #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [3:0]  hprot,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic        hreadyout,
    output logic [1:0]  hresp,
    output logic [31:0] hrdata,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WD_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE, S_WCAP, S_REQ, S_DONE, S_ERR1, S_ERR2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_wdog;
    logic            r_write;
    logic [31:0]     r_hrdata;
    logic            r_mem_instr;
    logic [31:0]     r_mem_addr;
    logic [31:0]     r_mem_wdata;
    logic [3:0]      r_mem_wstrb;

    logic            w_accept;
    logic            w_illegal;
    logic            w_start;
    logic            w_wd_expire;
    logic [3:0]      w_strb;
    logic            w_hreadyout;
    logic [1:0]      w_hresp;
    logic            w_unused;

    assign w_unused = ^{hprot[3:1], htrans[0]};

    assign w_accept = hsel && hready && htrans[1];
    assign w_illegal = (hsize > 3'b010)
                     || (hsize == 3'b001 && haddr[0])
                     || (hsize == 3'b010 && haddr[1:0] != 2'b00);
    assign w_wd_expire = (TIMEOUT > 0) && (r_wdog == WD_LAST);

    // Lane 0 of the address is the most significant byte.
    always_comb begin
        w_strb = 4'b1111;
        case (hsize)
            3'b000:  w_strb = 4'b1000 >> haddr[1:0];
            3'b001:  w_strb = haddr[1] ? 4'b0011 : 4'b1100;
            default: w_strb = 4'b1111;
        endcase
    end

    always_comb begin
        w_next      = r_state;
        w_hreadyout = 1'b1;
        w_hresp     = 2'b00;
        w_start     = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_ERR2: begin
                if (r_state == S_ERR2) w_hresp = 2'b01;
                w_next = S_IDLE;
                if (w_accept) begin
                    if (w_illegal) begin
                        w_next = S_ERR1;
                    end else begin
                        w_start = 1'b1;
                        w_next  = hwrite ? S_WCAP : S_REQ;
                    end
                end
            end
            S_WCAP: begin
                w_hreadyout = 1'b0;
                w_next      = S_REQ;
            end
            S_REQ: begin
                w_hreadyout = 1'b0;
                if (mem_ready)        w_next = S_DONE;
                else if (w_wd_expire) w_next = S_ERR1;
            end
            S_ERR1: begin
                w_hreadyout = 1'b0;
                w_hresp     = 2'b01;
                w_next      = S_ERR2;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_wdog      <= '0;
            r_write     <= 1'b0;
            r_hrdata    <= '0;
            r_mem_instr <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
        end else begin
            r_state <= w_next;
            r_wdog  <= (r_state == S_REQ && w_next == S_REQ) ? r_wdog + 1'b1 : '0;
            if (w_start) begin
                r_write     <= hwrite;
                r_mem_addr  <= {haddr[31:2], 2'b00};
                r_mem_wstrb <= hwrite ? w_strb : 4'b0000;
                r_mem_instr <= ~hprot[0];
            end
            if (r_state == S_WCAP) r_mem_wdata <= hwdata;
            if (r_state == S_REQ && mem_ready && !r_write) r_hrdata <= mem_rdata;
        end
    end

    assign hreadyout = w_hreadyout;
    assign hresp     = w_hresp;
    assign hrdata    = r_hrdata;
    assign mem_valid = (r_state == S_REQ);
    assign mem_instr = r_mem_instr;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wstrb = r_mem_wstrb;

endmodule

// File: tb/tb_ahb_to_picorv32_mem_bridge.sv
// Bench for ahb_to_picorv32_mem_bridge: fixed vector table, randomized transfers
// against a transaction-level model, and hand sequences for pipelining and reset.
module tb_ahb_to_picorv32_mem_bridge;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic [1:0]  hresp;
    logic [31:0] hrdata;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    ahb_to_picorv32_mem_bridge #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .hsel(hsel), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .hwdata(hwdata),
        .hready(hready), .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic [31:0] a;
        logic        w;
        logic [2:0]  sz;
        logic        p0;
        logic [31:0] wd;
        int          lat;   // mem_valid cycle on which the target answers; 0 = never
    } xfer_t;

    typedef struct {
        int          waits;
        logic [1:0]  hresp;
        logic [1:0]  last_hresp;
        int          nreq;
        int          vcnt;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic        instr;
        logic        unstable;
        logic [31:0] hrdata;
    } res_t;

    typedef struct {
        xfer_t x;
        res_t  e;
    } vec_t;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] tmem   [0:15];
    logic [31:0] shadow [0:15];
    logic [31:0] m_hrdata;
    vec_t        tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic res_t clr();
        res_t r;
        r.waits = 0; r.hresp = 2'b00; r.last_hresp = 2'b00; r.nreq = 0; r.vcnt = 0;
        r.addr = '0; r.wstrb = '0; r.wdata = '0; r.instr = 1'b0; r.unstable = 1'b0;
        r.hrdata = '0;
        return r;
    endfunction

    function automatic vec_t mk(input logic [31:0] a, input logic w, input logic [2:0] sz,
                                input logic p0, input logic [31:0] wd, input int lat,
                                input int waits, input logic [1:0] rsp, input int nreq,
                                input int vcnt, input logic [31:0] ea, input logic [3:0] es,
                                input logic ei, input logic [31:0] erd);
        vec_t v;
        v.x = '{a: a, w: w, sz: sz, p0: p0, wd: wd, lat: lat};
        v.e = clr();
        v.e.waits = waits; v.e.hresp = rsp; v.e.last_hresp = rsp; v.e.nreq = nreq;
        v.e.vcnt = vcnt; v.e.addr = ea; v.e.wstrb = es; v.e.wdata = wd; v.e.instr = ei;
        v.e.hrdata = erd;
        return v;
    endfunction

    // Transaction-level expectation: alignment from size, lanes counted big-endian.
    function automatic res_t model(input xfer_t x);
        res_t e;
        int   off;
        int   n;
        bit   done;
        e = clr();
        e.hrdata = m_hrdata;
        off = int'(x.a[1:0]);
        n = (x.sz <= 3'd2) ? (1 << x.sz) : 0;
        if (n == 0 || (off % n) != 0) begin
            e.waits = 1; e.hresp = 2'b01; e.last_hresp = 2'b01;
            return e;
        end
        e.nreq  = 1;
        e.addr  = x.a - 32'(off);
        e.wdata = x.wd;
        e.instr = !x.p0;
        for (int i = 0; i < n; i++)
            if (x.w) e.wstrb[3 - (off + i)] = 1'b1;
        done   = (x.lat >= 1 && x.lat <= TIMEOUT);
        e.vcnt = done ? x.lat : TIMEOUT;
        e.waits = e.vcnt + (x.w ? 1 : 0) + (done ? 0 : 1);
        if (!done) begin
            e.hresp = 2'b01; e.last_hresp = 2'b01;
        end else if (!x.w) begin
            e.hrdata = shadow[x.a[5:2]];
        end
        return e;
    endfunction

    function automatic void commit(input xfer_t x, input res_t e);
        if (e.nreq != 0 && e.hresp == 2'b00) begin
            if (x.w) begin
                for (int b = 0; b < 4; b++)
                    if (e.wstrb[b]) shadow[x.a[5:2]][8*b +: 8] = x.wd[8*b +: 8];
            end else begin
                m_hrdata = shadow[x.a[5:2]];
            end
        end
    endfunction

    task automatic idle_bus();
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'b010; hprot = 4'b0001;
    endtask

    // Drive one AHB transfer and act as the native target until the data phase ends.
    task automatic run(input xfer_t x, output res_t r);
        bit prev_valid;
        bit fin;
        r = clr();
        @(negedge clk);
        hsel = 1'b1; htrans = 2'b10; haddr = x.a; hwrite = x.w; hsize = x.sz;
        hprot = {3'b000, x.p0}; hwdata = $urandom;
        @(negedge clk);
        idle_bus();
        haddr = $urandom; hwdata = x.wd;
        prev_valid = 1'b0;
        fin = 1'b0;
        for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
            if (hreadyout) begin
                r.hresp = hresp; r.hrdata = hrdata; mem_ready = 1'b0;
                fin = 1'b1;
            end else begin
                r.waits++;
                r.last_hresp = hresp;
                mem_ready = 1'b0;
                mem_rdata = $urandom;
                if (mem_valid) begin
                    if (!prev_valid) begin
                        r.nreq++;
                        r.addr = mem_addr; r.wstrb = mem_wstrb;
                        r.wdata = mem_wdata; r.instr = mem_instr;
                    end else if (mem_addr !== r.addr || mem_wstrb !== r.wstrb ||
                                 mem_wdata !== r.wdata || mem_instr !== r.instr) begin
                        r.unstable = 1'b1;
                    end
                    r.vcnt++;
                    if (r.vcnt == x.lat) begin
                        mem_ready = 1'b1;
                        if (mem_wstrb == 4'b0000) begin
                            mem_rdata = tmem[mem_addr[5:2]];
                        end else begin
                            for (int b = 0; b < 4; b++)
                                if (mem_wstrb[b]) tmem[mem_addr[5:2]][8*b +: 8] = mem_wdata[8*b +: 8];
                        end
                    end
                end
                prev_valid = mem_valid;
                @(negedge clk);
            end
        end
        if (!fin) begin
            n_vec++; n_err++;
            $display("FAIL xfer_timeout: hreadyout still 0 after 300 cycles, expected 1");
            mem_ready = 1'b0;
        end
    endtask

    task automatic compare(input string tag, input xfer_t x, input res_t g, input res_t e);
        chk({tag, ".waits"}, 32'(g.waits), 32'(e.waits));
        chk({tag, ".hresp"}, 32'(g.hresp), 32'(e.hresp));
        chk({tag, ".wait_hresp"}, 32'(g.last_hresp), 32'(e.last_hresp));
        chk({tag, ".nreq"}, 32'(g.nreq), 32'(e.nreq));
        chk({tag, ".vcnt"}, 32'(g.vcnt), 32'(e.vcnt));
        chk({tag, ".hrdata"}, g.hrdata, e.hrdata);
        if (e.nreq != 0) begin
            chk({tag, ".addr"}, g.addr, e.addr);
            chk({tag, ".wstrb"}, 32'(g.wstrb), 32'(e.wstrb));
            chk({tag, ".instr"}, 32'(g.instr), 32'(e.instr));
            chk({tag, ".stable"}, 32'(g.unstable), 32'(0));
            if (x.w) chk({tag, ".wdata"}, g.wdata, e.wdata);
        end
    endtask

    initial begin
        xfer_t x;
        res_t  g;
        res_t  e;

        reset = 1'b1; idle_bus(); haddr = '0; hwdata = '0; hready = 1'b1;
        mem_ready = 1'b0; mem_rdata = '0;
        for (int i = 0; i < 16; i++) begin
            tmem[i] = '0; shadow[i] = '0;
        end
        tmem[4] = 32'hDEADBEEF; shadow[4] = 32'hDEADBEEF;
        tmem[8] = 32'hCAFEF00D; shadow[8] = 32'hCAFEF00D;
        m_hrdata = '0;

        repeat (3) @(negedge clk);
        chk("rst.hreadyout", 32'(hreadyout), 32'(1));
        chk("rst.hresp", 32'(hresp), 32'(0));
        chk("rst.hrdata", hrdata, 32'h0);
        chk("rst.mem_valid", 32'(mem_valid), 32'(0));
        chk("rst.mem_instr", 32'(mem_instr), 32'(0));
        chk("rst.mem_addr", mem_addr, 32'h0);
        chk("rst.mem_wdata", mem_wdata, 32'h0);
        chk("rst.mem_wstrb", 32'(mem_wstrb), 32'(0));
        reset = 1'b0;

        //        addr          w  sz  p0 wdata         lat waits rsp nreq vcnt addr          wstrb   i  hrdata
        tbl.push_back(mk(32'h40000010, 0, 2, 1, 32'h0,        4,  4,  0,  1,  4, 32'h40000010, 4'b0000, 0, 32'hDEADBEEF));
        tbl.push_back(mk(32'h40000003, 1, 0, 1, 32'h000000AB, 1,  2,  0,  1,  1, 32'h40000000, 4'b0001, 0, 32'hDEADBEEF));
        tbl.push_back(mk(32'h40000002, 1, 1, 1, 32'h00001234, 2,  3,  0,  1,  2, 32'h40000000, 4'b0011, 0, 32'hDEADBEEF));
        tbl.push_back(mk(32'h40000000, 1, 1, 1, 32'h56780000, 1,  2,  0,  1,  1, 32'h40000000, 4'b1100, 0, 32'hDEADBEEF));
        tbl.push_back(mk(32'h40000001, 1, 2, 1, 32'h11111111, 1,  1,  1,  0,  0, 32'h0,        4'b0000, 0, 32'hDEADBEEF));
        tbl.push_back(mk(32'h40000000, 0, 2, 0, 32'h0,        1,  1,  0,  1,  1, 32'h40000000, 4'b0000, 1, 32'h56781234));
        tbl.push_back(mk(32'h40000001, 0, 1, 1, 32'h0,        1,  1,  1,  0,  0, 32'h0,        4'b0000, 0, 32'h56781234));
        tbl.push_back(mk(32'h40000000, 0, 3, 1, 32'h0,        1,  1,  1,  0,  0, 32'h0,        4'b0000, 0, 32'h56781234));
        tbl.push_back(mk(32'h40000020, 0, 2, 1, 32'h0,       64, 64,  0,  1, 64, 32'h40000020, 4'b0000, 0, 32'hCAFEF00D));
        tbl.push_back(mk(32'h40000024, 0, 2, 1, 32'h0,        0, 65,  1,  1, 64, 32'h40000024, 4'b0000, 0, 32'hCAFEF00D));
        tbl.push_back(mk(32'h40000012, 1, 0, 1, 32'h0000EF00, 2,  3,  0,  1,  2, 32'h40000010, 4'b0010, 0, 32'hCAFEF00D));
        tbl.push_back(mk(32'h40000010, 0, 2, 1, 32'h0,        1,  1,  0,  1,  1, 32'h40000010, 4'b0000, 0, 32'hDEADEFEF));
        tbl.push_back(mk(32'h40000018, 1, 2, 1, 32'h13579BDF, 0, 66,  1,  1, 64, 32'h40000018, 4'b1111, 0, 32'hDEADEFEF));

        for (int i = 0; i < tbl.size(); i++) begin
            run(tbl[i].x, g);
            compare($sformatf("vec%0d", i), tbl[i].x, g, tbl[i].e);
            commit(tbl[i].x, model(tbl[i].x));
        end

        for (int i = 0; i < 40; i++) begin
            x.a  = 32'h40000000 | 32'($urandom_range(0, 63));
            x.w  = 1'($urandom_range(0, 1));
            x.sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            if (x.sz <= 3'd2 && $urandom_range(0, 1) == 1)
                x.a = x.a & ~((32'd1 << x.sz) - 32'd1);
            x.p0  = 1'($urandom_range(0, 1));
            x.wd  = $urandom;
            x.lat = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 6));
            e = model(x);
            run(x, g);
            compare($sformatf("rnd%0d", i), x, g, e);
            commit(x, e);
        end

        // Second transfer presented in the DONE cycle of the first
        @(negedge clk);
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h40000032; hwrite = 1'b1; hsize = 3'b001;
        hprot = 4'b0001;
        @(negedge clk);
        idle_bus(); hwdata = 32'h0000BEEF;
        chk("b2b.wcap1_hreadyout", 32'(hreadyout), 32'(0));
        @(negedge clk);
        chk("b2b.req1_valid", 32'(mem_valid), 32'(1));
        chk("b2b.req1_wstrb", 32'(mem_wstrb), 32'(4'b0011));
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("b2b.done1_hreadyout", 32'(hreadyout), 32'(1));
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h40000030; hwrite = 1'b1; hsize = 3'b001;
        @(negedge clk);
        chk("b2b.accept_in_done", 32'(hreadyout), 32'(0));
        chk("b2b.no_gap_valid", 32'(mem_valid), 32'(0));
        idle_bus(); hwdata = 32'hF00D0000;
        @(negedge clk);
        chk("b2b.req2_valid", 32'(mem_valid), 32'(1));
        chk("b2b.req2_wstrb", 32'(mem_wstrb), 32'(4'b1100));
        chk("b2b.req2_addr", mem_addr, 32'h40000030);
        chk("b2b.req2_wdata", mem_wdata, 32'hF00D0000);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("b2b.done2_hreadyout", 32'(hreadyout), 32'(1));
        chk("b2b.done2_hresp", 32'(hresp), 32'(0));

        // Reset while a read request is outstanding
        @(negedge clk);
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h40000010; hwrite = 1'b0; hsize = 3'b010;
        @(negedge clk);
        idle_bus();
        chk("rreq.valid", 32'(mem_valid), 32'(1));
        reset = 1'b1;
        @(negedge clk);
        chk("rreq.valid_dropped", 32'(mem_valid), 32'(0));
        chk("rreq.hreadyout", 32'(hreadyout), 32'(1));
        chk("rreq.hresp", 32'(hresp), 32'(0));
        reset = 1'b0;
        mem_ready = 1'b1; mem_rdata = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("late%0d.valid", i), 32'(mem_valid), 32'(0));
            chk($sformatf("late%0d.hreadyout", i), 32'(hreadyout), 32'(1));
            chk($sformatf("late%0d.hrdata", i), hrdata, 32'h0);
        end
        mem_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
